// File: rtl/data_mem_if.sv
// CPU data-bus connection to the data-memory responder.
// Handshake: the CPU holds mem_read or mem_wrt (with addr_bus and data_bus_out) until a
// one-cycle mem_ready pulse. mem_err and data_bus_in are meaningful only while mem_ready is high.
interface data_mem_if;
    logic [31:0] addr_bus;
    logic [31:0] data_bus_out;
    logic        mem_read;
    logic        mem_wrt;
    logic [31:0] data_bus_in;
    logic        mem_ready;
    logic        mem_err;
    logic        mem_busy;
    logic [1:0]  fsm_state;

    modport master (
        output addr_bus, data_bus_out, mem_read, mem_wrt,
        input  data_bus_in, mem_ready, mem_err, mem_busy, fsm_state
    );

    modport slave (
        input  addr_bus, data_bus_out, mem_read, mem_wrt,
        output data_bus_in, mem_ready, mem_err, mem_busy, fsm_state
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with programmable wait states and a mem_ready completion pulse.
// Illegal accesses (misaligned, out of range, read+write conflict) are flagged and never write.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t state, next_state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_data;
    logic                  lat_rd, lat_wr, lat_err;

    logic [31:0] ram [2**ADDR_WIDTH];

    logic                  req, req_err, commit;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_data;
    logic                  cur_rd, cur_wr, cur_err;

    assign req     = bus.mem_read | bus.mem_wrt;
    assign req_err = (bus.addr_bus[1:0] != 2'b00)
                   | ((bus.addr_bus >> (ADDR_WIDTH + 2)) != 32'd0)
                   | (bus.mem_read & bus.mem_wrt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt <= 4'd1) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // With no wait states the commit edge is also the sampling edge, so the live
    // request is used in IDLE and the latched one afterwards.
    always_comb begin
        bus.mem_busy  = (state != ST_IDLE);
        bus.fsm_state = state;
        commit        = (next_state == ST_RESP) && (state != ST_RESP);
        cur_idx       = lat_idx;
        cur_data      = lat_data;
        cur_rd        = lat_rd;
        cur_wr        = lat_wr;
        cur_err       = lat_err;
        if (state == ST_IDLE) begin
            cur_idx  = bus.addr_bus[ADDR_WIDTH+1:2];
            cur_data = bus.data_bus_out;
            cur_rd   = bus.mem_read;
            cur_wr   = bus.mem_wrt;
            cur_err  = req_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= 4'd0;
            lat_idx         <= '0;
            lat_data        <= 32'd0;
            lat_rd          <= 1'b0;
            lat_wr          <= 1'b0;
            lat_err         <= 1'b0;
            bus.data_bus_in <= 32'd0;
            bus.mem_ready   <= 1'b0;
            bus.mem_err     <= 1'b0;
        end else begin
            if (state == ST_IDLE && req) begin
                cnt      <= WAIT_LOAD;
                lat_idx  <= bus.addr_bus[ADDR_WIDTH+1:2];
                lat_data <= bus.data_bus_out;
                lat_rd   <= bus.mem_read;
                lat_wr   <= bus.mem_wrt;
                lat_err  <= req_err;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            bus.mem_ready <= commit;
            bus.mem_err   <= commit & cur_err;
            if (commit && cur_rd)
                bus.data_bus_in <= cur_err ? 32'd0 : ram[cur_idx];
        end
    end

    // RAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_wr && !cur_err)
            ram[cur_idx] <= cur_data;
    end
endmodule
